// File: rtl/frame_write_sequencer.sv
// Byte-to-pixel write sequencer: packs R,G,B bytes into 24-bit pixels and
// issues raster-order writes with internally generated pixel/line coordinates.
module frame_write_sequencer #(
    parameter int H_PIXELS = 110,
    parameter int V_LINES  = 110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    input  logic        wr_ready,
    output logic [9:0]  wr_px,
    output logic [9:0]  wr_line,
    output logic [23:0] wr_data,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        B0    = 3'd1,
        B1    = 3'd2,
        B2    = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [9:0] PX_LAST   = 10'(H_PIXELS - 1);
    localparam logic [9:0] LINE_LAST = 10'(V_LINES - 1);

    state_t      state_reg, state_next;
    logic [9:0]  px_reg, px_next;
    logic [9:0]  line_reg, line_next;
    logic [23:0] data_reg, data_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            px_reg    <= '0;
            line_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            px_reg    <= px_next;
            line_reg  <= line_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        px_next    = px_reg;
        line_next  = line_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    state_next = B0;
                    px_next    = '0;
                    line_next  = '0;
                end
            end
            B0: begin
                if (byte_valid) begin
                    data_next[23:16] = byte_in;
                    state_next       = B1;
                end
            end
            B1: begin
                if (byte_valid) begin
                    data_next[15:8] = byte_in;
                    state_next      = B2;
                end
            end
            B2: begin
                if (byte_valid) begin
                    data_next[7:0] = byte_in;
                    state_next     = WRITE;
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    if (px_reg == PX_LAST) begin
                        px_next = '0;
                        if (line_reg == LINE_LAST) begin
                            line_next  = '0;
                            state_next = DONE;
                        end else begin
                            line_next  = line_reg + 10'd1;
                            state_next = B0;
                        end
                    end else begin
                        px_next    = px_reg + 10'd1;
                        state_next = B0;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                px_next    = '0;
                line_next  = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Abort wins over everything, including a write handshake this cycle.
        if (abort) begin
            state_next = IDLE;
            px_next    = '0;
            line_next  = '0;
            data_next  = '0;
        end
    end

    assign byte_ready = (state_reg == B0) || (state_reg == B1) || (state_reg == B2);
    assign wr_en      = (state_reg == WRITE);
    assign busy       = (state_reg != IDLE);
    assign frame_done = (state_reg == DONE);
    assign wr_px      = px_reg;
    assign wr_line    = line_reg;
    assign wr_data    = data_reg;

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Randomized bench for frame_write_sequencer; expected writes are derived from
// the byte stream as pixel k = {b[3k],b[3k+1],b[3k+2]} at (k % H, k / H).
module tb_frame_write_sequencer;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        wr_en;
    logic        wr_ready = 1'b0;
    logic [9:0]  wr_px;
    logic [9:0]  wr_line;
    logic [23:0] wr_data;
    logic        busy;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [9:0]  px;
        logic [9:0]  line;
        logic [23:0] data;
    } wr_t;

    wr_t obs_q[$];
    int  done_cnt = 0;

    frame_write_sequencer #(.H_PIXELS(H), .V_LINES(V)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_px(wr_px), .wr_line(wr_line),
        .wr_data(wr_data), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge, so at the falling edge they
    // describe the handshake that completes on the next rising edge.
    always @(negedge clk) begin
        wr_t w;
        if (reset && wr_en && wr_ready && !abort) begin
            w.px   = wr_px;
            w.line = wr_line;
            w.data = wr_data;
            obs_q.push_back(w);
            $display("write px=%0d line=%0d data=%06h", wr_px, wr_line, wr_data);
        end
        if (reset && frame_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string name);
        vectors++;
        if ({byte_ready, wr_en, busy, frame_done} !== 4'b0000 || wr_px !== 10'd0 ||
            wr_line !== 10'd0) begin
            miscompares++;
            $display("FAIL %s: ready/wr_en/busy/done=%b px=%0d line=%0d, required 0000 px=0 line=0",
                     name, {byte_ready, wr_en, busy, frame_done}, wr_px, wr_line);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        check_idle_outputs("reset_state");
        vectors++;
        if (wr_data !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %06h, required 000000", wr_data);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_idle_outputs("post_reset_idle");
    endtask

    // mode 0: continuous, 1: byte_valid toggles, 2: random valid/ready/frame_start,
    // 3: wr_ready held low for the first 5 cycles of every write
    task automatic run_frame(input int mode, input string name);
        logic [7:0] bytes [NPIX*3];
        wr_t        w;
        logic [23:0] exp_data;
        int wbase, dbase, idx, cyc, hold, done_cyc, k;
        for (int i = 0; i < NPIX*3; i++) bytes[i] = 8'($urandom);
        wbase = obs_q.size();
        dbase = done_cnt;
        idx = 0; cyc = 0; hold = 0; done_cyc = -1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        while (cyc < 3000) begin
            cyc++;
            if (frame_done) begin
                done_cyc = cyc;
                break;
            end
            case (mode)
                1:       byte_valid = (cyc % 2) == 1;
                2:       byte_valid = 1'($urandom_range(0, 1));
                default: byte_valid = 1'b1;
            endcase
            byte_in = (idx < NPIX*3) ? bytes[idx] : 8'($urandom);
            frame_start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (mode == 2) begin
                wr_ready = 1'($urandom_range(0, 1));
            end else if (mode == 3 && wr_en && hold < 5) begin
                wr_ready = 1'b0;
                k = obs_q.size() - wbase;
                exp_data = {bytes[3*k], bytes[3*k+1], bytes[3*k+2]};
                hold++;
                vectors++;
                if (!wr_en || byte_ready || wr_data !== exp_data ||
                    wr_px !== 10'(k % H) || wr_line !== 10'(k / H)) begin
                    miscompares++;
                    $display("FAIL %s hold: wr_en=%b ready=%b data=%06h px=%0d line=%0d, required 1 0 %06h %0d %0d",
                             name, wr_en, byte_ready, wr_data, wr_px, wr_line,
                             exp_data, k % H, k / H);
                end
            end else begin
                wr_ready = 1'b1;
                if (mode == 3 && wr_en) hold = 0;
            end
            if (byte_valid && byte_ready) idx++;
            tick();
        end
        frame_start = 1'b0;
        byte_valid  = 1'b0;
        wr_ready    = 1'b0;
        vectors++;
        if (done_cyc < 0) begin
            miscompares++;
            $display("FAIL %s timeout: no frame_done after %0d cycles", name, cyc);
        end
        if (mode == 0) begin
            vectors++;
            if (done_cyc != 4*NPIX + 1) begin
                miscompares++;
                $display("FAIL %s latency: frame_done in cycle %0d, required %0d",
                         name, done_cyc, 4*NPIX + 1);
            end
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || done_cnt - dbase != 1) begin
            miscompares++;
            $display("FAIL %s end: busy=%b done_pulses=%0d, required 0 and 1",
                     name, busy, done_cnt - dbase);
        end
        vectors++;
        if (obs_q.size() - wbase != NPIX || idx != NPIX*3) begin
            miscompares++;
            $display("FAIL %s count: writes=%0d bytes=%0d, required %0d and %0d",
                     name, obs_q.size() - wbase, idx, NPIX, NPIX*3);
        end
        for (int p = 0; p < NPIX && wbase + p < obs_q.size(); p++) begin
            w = obs_q[wbase + p];
            exp_data = {bytes[3*p], bytes[3*p+1], bytes[3*p+2]};
            vectors++;
            if (w.data !== exp_data || w.px !== 10'(p % H) || w.line !== 10'(p / H)) begin
                miscompares++;
                $display("FAIL %s pixel%0d: data=%06h px=%0d line=%0d, required %06h %0d %0d",
                         name, p, w.data, w.px, w.line, exp_data, p % H, p / H);
            end
        end
        $display("frame %s: %0d writes, frame_done cycle %0d", name, obs_q.size() - wbase, done_cyc);
    endtask

    task automatic test_reset_mid();
        int idx = 0;
        int cyc = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wr_ready = 1'b1;
        byte_in = 8'hA5;
        // 5 pixels written plus the R byte of pixel 5 puts the FSM in B1
        while (idx < 16 && cyc < 200) begin
            cyc++;
            byte_valid = 1'b1;
            if (byte_ready) idx++;
            tick();
        end
        byte_valid = 1'b0;
        vectors++;
        if (idx != 16 || !byte_ready) begin
            miscompares++;
            $display("FAIL reset_mid setup: bytes=%0d ready=%b, required 16 and 1", idx, byte_ready);
        end
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("reset_mid_async");
        vectors++;
        if (wr_data !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_mid_data: got %06h, required 000000", wr_data);
        end
        tick();
        reset = 1'b1;
        tick();
        check_idle_outputs("reset_mid_release");
        run_frame(0, "after_reset");
    endtask

    task automatic test_abort();
        int wbase = obs_q.size();
        int dbase = done_cnt;
        int cyc = 0;
        frame_start = 1'b1;
        tick();
        wr_ready = 1'b1;
        byte_in = 8'h3C;
        while (!(wr_en && obs_q.size() == wbase + 1) && cyc < 200) begin
            cyc++;
            byte_valid  = 1'b1;
            frame_start = 1'($urandom_range(0, 1));
            tick();
        end
        byte_valid  = 1'b0;
        frame_start = 1'b0;
        vectors++;
        if (obs_q.size() != wbase + 1 || obs_q[wbase].px !== 10'd0 || obs_q[wbase].line !== 10'd0) begin
            miscompares++;
            $display("FAIL abort setup: writes=%0d, required 1 at (0,0)", obs_q.size() - wbase);
        end
        vectors++;
        if (!wr_en || wr_px !== 10'd1) begin
            miscompares++;
            $display("FAIL abort pre: wr_en=%b px=%0d, required 1 and 1", wr_en, wr_px);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle_outputs("abort_idle");
        repeat (3) tick();
        vectors++;
        if (obs_q.size() != wbase + 1 || done_cnt != dbase || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort after: writes=%0d done_pulses=%0d busy=%b, required 1 0 0",
                     obs_q.size() - wbase, done_cnt - dbase, busy);
        end
        wr_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        run_frame(0, "line_wrap");
        run_frame(1, "gapped");
        run_frame(3, "back_pressure");
        for (int r = 0; r < 3; r++) run_frame(2, "random");
        test_reset_mid();
        test_abort();
        run_frame(0, "back_to_back_after_abort");
        run_frame(0, "back_to_back");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_write_sequencer.md
# frame_write_sequencer

Sequences writes into the frame line buffer. Accepts an 8-bit RGB byte stream over a valid/ready handshake, assembles each three-byte group into one 24-bit pixel, and issues one write per pixel with the pixel and line coordinates generated internally. A full frame is written in raster order, then `frame_done` is flagged. Sits between the byte source (host/DMA side) and the frame storage block, replacing externally supplied pixel/line indices.

## Interface

Parameters:
- `H_PIXELS`, 110: pixels per line, range 1..1024.
- `V_LINES`, 110: lines per frame, range 1..1024.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  start a frame; sampled only in IDLE.
- `abort`  in  1  synchronous frame abort; any state.
- `byte_in`  in  8  stream byte, R then G then B.
- `byte_valid`  in  1  `byte_in` valid.
- `byte_ready`  out  1  sequencer accepts `byte_in` this cycle.
- `wr_en`  out  1  pixel write request.
- `wr_ready`  in  1  storage accepts write this cycle.
- `wr_px`  out  10  pixel index of current write.
- `wr_line`  out  10  line index of current write.
- `wr_data`  out  24  pixel, [23:16]=R, [15:8]=G, [7:0]=B.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse after last pixel written.

## Operation

- States: IDLE, B0, B1, B2, WRITE, DONE.
- IDLE: `busy`=0, `byte_ready`=0. `frame_start`=1 -> B0; `wr_px`=0, `wr_line`=0.
- B0/B1/B2: `byte_ready`=1, `busy`=1. Transfer occurs when `byte_valid`&&`byte_ready`. B0 captures into [23:16] -> B1; B1 captures into [15:8] -> B2; B2 captures into [7:0] -> WRITE. No transfer: hold state.
- WRITE: `wr_en`=1, `byte_ready`=0; `wr_data`, `wr_px`, `wr_line` stable until accepted. On `wr_en`&&`wr_ready`:
  - `wr_px`==H_PIXELS-1 and `wr_line`==V_LINES-1 -> DONE.
  - `wr_px`==H_PIXELS-1 -> `wr_px`=0, `wr_line`+1, -> B0.
  - otherwise `wr_px`+1 -> B0.
- DONE: `frame_done`=1 for exactly one cycle, `busy`=1 -> IDLE. Coordinates return to 0.
- `frame_start` while not IDLE: ignored.
- `abort`=1: -> IDLE next edge from any state, coordinates 0, partial pixel discarded, no write issued that cycle if already in WRITE (write is dropped even if `wr_ready`=1 same cycle), no `frame_done`. `abort` has priority over `frame_start` and all transfers.
- Counters are 10-bit unsigned; coordinates never exceed H_PIXELS-1 / V_LINES-1.

## Timing

- Reset (async assert, `reset`=0): state IDLE; `byte_ready`=0, `wr_en`=0, `wr_px`=0, `wr_line`=0, `wr_data`=0, `busy`=0, `frame_done`=0. Release synchronous to `clk`.
- All outputs registered or decoded from registered state only; no combinational path from `byte_valid`/`wr_ready` to any output.
- `frame_start` at edge N -> `busy`=1, `byte_ready`=1 from cycle N+1.
- Third byte accepted at edge N -> `wr_en`=1 during cycle N+1.
- Write accepted at edge M -> `byte_ready`=1 during cycle M+1 (not last pixel), or `frame_done`=1 during M+1 (last pixel), `busy`=0 from M+2.
- Peak throughput: 1 pixel per 4 cycles; frame minimum 4*H_PIXELS*V_LINES + 2 cycles from `frame_start`.
- `wr_ready` low holds WRITE indefinitely; stream is back-pressured.

## Test plan

- Reset mid-frame (assert `reset`=0 in B1 of pixel 5): all outputs at reset values immediately; next `frame_start` writes from px 0, line 0.
- Single pixel, H=V=1: bytes 0x12,0x34,0x56 continuous -> one `wr_en` with `wr_data`=0x123456, px 0, line 0; `frame_done` pulse on following cycle; `busy` low one cycle later.
- Line wrap, H=4,V=2, continuous stream: writes at (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1); exactly 8 writes, one `frame_done`, total 34 cycles from `frame_start`.
- Back-pressure: hold `wr_ready`=0 for 5 cycles in WRITE -> `wr_en`,`wr_data`,`wr_px`,`wr_line` unchanged, `byte_ready`=0 throughout; write completes once `wr_ready`=1.
- Gapped input: `byte_valid` toggling 1/0 each cycle -> pixels identical to continuous case, one write per 3 accepted bytes.
- Abort: `abort`=1 while in WRITE with `wr_ready`=1 -> no write counted, IDLE next cycle, no `frame_done`; `frame_start` pulses during busy have no effect.
